// File: rtl/accel_pkg.sv
// Shared types and arithmetic for the systolic MAC grid.
// MAC_SATURATE_EN selects saturating accumulation instead of wrap.
package accel_pkg;

   localparam int NUM_SIZE_DEF  = 16;
   localparam int GRID_SIZE_DEF = 2;
   localparam int MAX_K_DEF     = 32;

`ifdef MAC_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      FLUSH,
      DRAIN
   } state_e;

   // Returns {overflow, sum}; sum is exact in 64 bits, clamped to w bits
   // when sat is set, otherwise the caller keeps the low w bits (wrap).
   function automatic logic [64:0] acc_step(
      input logic signed [63:0] acc,
      input logic signed [63:0] prod,
      input int                 w,
      input bit                 sat
   );
      logic signed [64:0] sum;
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      logic        [64:0] r;
      sum = {acc[63], acc} + {prod[63], prod};
      hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
      lo  = -hi - 65'sd1;
      if (sat && (sum > hi)) begin
         r = {1'b1, hi[63:0]};
      end else if (sat && (sum < lo)) begin
         r = {1'b1, lo[63:0]};
      end else begin
         r = {1'b0, sum[63:0]};
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_pe.sv
// One processing element: a/b pass registers and a local accumulator.
// Everything advances only on en; clr zeroes all state for a new job.
module mac_pe
   import accel_pkg::*;
#(
   parameter int NUM_SIZE = NUM_SIZE_DEF,
   parameter int ACC_SIZE = 2 * NUM_SIZE_DEF + 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       clr,
   input  logic signed [NUM_SIZE-1:0] a_in,
   input  logic signed [NUM_SIZE-1:0] b_in,
   output logic signed [NUM_SIZE-1:0] a_out,
   output logic signed [NUM_SIZE-1:0] b_out,
   output logic signed [ACC_SIZE-1:0] acc_out,
   output logic                       ovf_out
);

   logic signed [NUM_SIZE-1:0]   a_q, a_d;
   logic signed [NUM_SIZE-1:0]   b_q, b_d;
   logic signed [ACC_SIZE-1:0]   acc_q, acc_d;
   logic signed [2*NUM_SIZE-1:0] prod;
   logic signed [63:0]           acc_x;
   logic signed [63:0]           prod_x;
   logic        [64:0]           step_res;

   always_comb begin
      prod     = a_in * b_in;
      acc_x    = {{(64-ACC_SIZE){acc_q[ACC_SIZE-1]}}, acc_q};
      prod_x   = {{(64-2*NUM_SIZE){prod[2*NUM_SIZE-1]}}, prod};
      step_res = acc_step(acc_x, prod_x, ACC_SIZE, SAT_EN);
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      ovf_out  = 1'b0;
      if (clr) begin
         a_d   = '0;
         b_d   = '0;
         acc_d = '0;
      end else if (en) begin
         a_d     = a_in;
         b_d     = b_in;
         acc_d   = step_res[ACC_SIZE-1:0];
         ovf_out = step_res[64];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

   assign a_out   = a_q;
   assign b_out   = b_q;
   assign acc_out = acc_q;

endmodule

// File: rtl/systolic_mac_grid.sv
// Output-stationary GxG systolic MAC array with skewed operand feed.
// Build with MAC_SATURATE_EN for saturating accumulators and a live ovf.
module systolic_mac_grid
   import accel_pkg::*;
#(
   parameter int NUM_SIZE  = NUM_SIZE_DEF,
   parameter int GRID_SIZE = GRID_SIZE_DEF,
   parameter int MAX_K     = MAX_K_DEF,
   parameter int ACC_SIZE  = 2 * NUM_SIZE + $clog2(MAX_K),
   localparam int KW       = $clog2(MAX_K + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [KW-1:0]                 k_len,
   input  logic                          a_valid,
   output logic                          a_ready,
   input  logic [GRID_SIZE*NUM_SIZE-1:0] a_data,
   input  logic [GRID_SIZE*NUM_SIZE-1:0] b_data,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [GRID_SIZE*ACC_SIZE-1:0] res_data,
   output logic                          busy,
   output logic                          done,
   output logic                          ovf
);

   localparam int G       = GRID_SIZE;
   localparam int FW      = $clog2(2 * G);
   localparam int RW      = (G > 1) ? $clog2(G) : 1;
   localparam int FLUSH_N = 2 * G - 2;

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [KW-1:0] beat_q, beat_d;
   logic [FW-1:0] flush_q, flush_d;
   logic [RW-1:0] row_q, row_d;
   logic          a_ready_q, a_ready_d;
   logic          res_valid_q, res_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          fire;
   logic          step;
   logic          clr;

   logic [NUM_SIZE-1:0] inj_a [G];
   logic [NUM_SIZE-1:0] inj_b [G];
   logic [NUM_SIZE-1:0] ska_q [G][G];
   logic [NUM_SIZE-1:0] ska_d [G][G];
   logic [NUM_SIZE-1:0] skb_q [G][G];
   logic [NUM_SIZE-1:0] skb_d [G][G];
   logic [NUM_SIZE-1:0] lane_a [G];
   logic [NUM_SIZE-1:0] lane_b [G];

   logic signed [NUM_SIZE-1:0] a_w   [G][G];
   logic signed [NUM_SIZE-1:0] b_w   [G][G];
   logic signed [ACC_SIZE-1:0] acc_w [G][G];
   logic [G*G-1:0]             pe_ovf;

   assign fire = a_valid & a_ready_q;
   assign step = ((state_q == FEED) & fire) | (state_q == FLUSH);

   // Zeros are injected outside FEED so flush steps drain cleanly.
   always_comb begin
      for (int i = 0; i < G; i++) begin
         inj_a[i] = '0;
         inj_b[i] = '0;
         if (state_q == FEED) begin
            inj_a[i] = a_data[i*NUM_SIZE +: NUM_SIZE];
            inj_b[i] = b_data[i*NUM_SIZE +: NUM_SIZE];
         end
      end
   end

   always_comb begin
      ska_d = ska_q;
      skb_d = skb_q;
      for (int i = 0; i < G; i++) begin
         for (int d = 0; d < G; d++) begin
            if (clr) begin
               ska_d[i][d] = '0;
               skb_d[i][d] = '0;
            end else if (step && (d == 0)) begin
               ska_d[i][d] = inj_a[i];
               skb_d[i][d] = inj_b[i];
            end else if (step && (d < i)) begin
               ska_d[i][d] = ska_q[i][d-1];
               skb_d[i][d] = skb_q[i][d-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ska_q <= '{default: '0};
         skb_q <= '{default: '0};
      end else begin
         ska_q <= ska_d;
         skb_q <= skb_d;
      end
   end

   for (genvar i = 0; i < G; i++) begin : g_lane
      if (i == 0) begin : g_direct
         assign lane_a[i] = inj_a[i];
         assign lane_b[i] = inj_b[i];
      end else begin : g_skew
         assign lane_a[i] = ska_q[i][i-1];
         assign lane_b[i] = skb_q[i][i-1];
      end
   end

   for (genvar i = 0; i < G; i++) begin : g_row
      for (genvar j = 0; j < G; j++) begin : g_col
         logic signed [NUM_SIZE-1:0] a_src;
         logic signed [NUM_SIZE-1:0] b_src;
         if (j == 0) begin : g_a_edge
            assign a_src = lane_a[i];
         end else begin : g_a_pass
            assign a_src = a_w[i][j-1];
         end
         if (i == 0) begin : g_b_edge
            assign b_src = lane_b[j];
         end else begin : g_b_pass
            assign b_src = b_w[i-1][j];
         end
         mac_pe #(
            .NUM_SIZE(NUM_SIZE),
            .ACC_SIZE(ACC_SIZE)
         ) u_pe (
            .clk    (clk),
            .rst    (rst),
            .en     (step),
            .clr    (clr),
            .a_in   (a_src),
            .b_in   (b_src),
            .a_out  (a_w[i][j]),
            .b_out  (b_w[i][j]),
            .acc_out(acc_w[i][j]),
            .ovf_out(pe_ovf[i*G+j])
         );
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      beat_d  = beat_q;
      flush_d = flush_q;
      row_d   = row_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               clr     = 1'b1;
               k_d     = k_len;
               beat_d  = '0;
               row_d   = '0;
               state_d = (k_len != '0) ? FEED : DRAIN;
            end
         end
         FEED: begin
            if (fire) begin
               beat_d = beat_q + 1'b1;
               if ((beat_q + 1'b1) == k_q) begin
                  flush_d = '0;
                  state_d = (FLUSH_N == 0) ? DRAIN : FLUSH;
               end
            end
         end
         FLUSH: begin
            flush_d = flush_q + 1'b1;
            if (flush_q == FW'(FLUSH_N - 1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (res_ready) begin
               if (row_q == RW'(G - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      a_ready_d   = (state_d == FEED);
      res_valid_d = (state_d == DRAIN);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         beat_q      <= '0;
         flush_q     <= '0;
         row_q       <= '0;
         a_ready_q   <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         beat_q      <= beat_d;
         flush_q     <= flush_d;
         row_q       <= row_d;
         a_ready_q   <= a_ready_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Accumulators are frozen in DRAIN, so the row mux output stays stable.
   always_comb begin
      res_data = '0;
      if (res_valid_q) begin
         for (int j = 0; j < G; j++) begin
            res_data[j*ACC_SIZE +: ACC_SIZE] = acc_w[row_q][j];
         end
      end
   end

`ifdef MAC_SATURATE_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (clr) begin
         ovf_d = 1'b0;
      end else if (step && (|pe_ovf)) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign a_ready   = a_ready_q;
   assign res_valid = res_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
